instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch sequencer directly downstream of the 16-bit program counter: consumes the PC value, reads the instruction word from memory over a req/ack handshake, and presents it to decode over a valid/ready handshake.
- Drives the PC's increment and load controls, so it owns PC advance and branch redirect.
- Single-entry instruction buffer; one memory transaction outstanding at most.

Parameters:
- DATA_WIDTH, 16, instruction/memory data width
- ADDR_WIDTH, 16, PC/memory address width
- TIMEOUT_CYCLES, 255, max cycles of mem_req without mem_ack before fetch_error; counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  allow new fetches
- pc_in  in  ADDR_WIDTH  current PC value from program counter
- pc_inc  out  1  combinational; PC increments at this edge
- pc_load  out  1  combinational; PC loads pc_load_value at this edge
- pc_load_value  out  ADDR_WIDTH  = redirect_addr
- redirect_valid  in  1  branch/jump request from execute
- redirect_addr  in  ADDR_WIDTH  branch target
- mem_req  out  1  registered read request
- mem_addr  out  ADDR_WIDTH  registered read address (addr_q)
- mem_ack  in  1  read data valid, single cycle
- mem_rdata  in  DATA_WIDTH  read data
- instr  out  DATA_WIDTH  fetched instruction
- instr_pc  out  ADDR_WIDTH  address instr was fetched from
- instr_valid  out  1  instr available to decode
- instr_ready  in  1  decode accepts instr
- fetch_error  out  1  sticky memory timeout flag

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous assert, active-low. While reset_n=0: state IDLE; mem_req, instr_valid, fetch_error, timeout count = 0; addr_q, instr, instr_pc = 0; pc_inc, pc_load forced 0. Reset mid-transaction drops mem_req at once; the memory abandons the request.
- States: IDLE, ISSUE, REQ, HOLD, DRAIN.
- IDLE: go to ISSUE if enable=1 and fetch_error=0.
- ISSUE: mem_req=0. addr_q <= pc_in. Then go to REQ.
- REQ: mem_req=1 and addr_q held stable until ack.
  - On mem_ack: instr <= mem_rdata, instr_pc <= addr_q, instr_valid <= 1, pc_inc=1 the same cycle, go to HOLD.
- HOLD: instr_valid=1 and instr held stable.
  - On instr_ready=1: instr_valid <= 0, then ISSUE if enable=1, else IDLE.
- PC timing: pc_inc/pc_load are Mealy outputs, so the PC updates at the same edge as the state transition. ISSUE therefore samples the updated pc_in.
- Latency: IDLE→ISSUE→REQ, so mem_req rises 2 cycles after enable is sampled. With zero-wait memory, instr_valid rises at the 3rd edge.
- Redirect: redirect_valid=1 in any state (reset_n=1) → pc_load=1 and pc_load_value=redirect_addr that cycle; instr_valid <= 0 (buffered instr discarded); pc_inc suppressed. Next state:
  - REQ with mem_ack=0 → DRAIN.
  - REQ with mem_ack=1 → data discarded, go to ISSUE.
  - ISSUE/HOLD → ISSUE.
  - IDLE → stay IDLE (PC still loaded).
- DRAIN: mem_req stays 1 with addr_q unchanged until mem_ack; data discarded; then ISSUE. Redirect in DRAIN reloads the PC and stays in DRAIN.
- Handshake rule: once mem_req rises, it and mem_addr stay constant until mem_ack or timeout.
- enable=0 does not abort an in-flight transaction; it only blocks IDLE→ISSUE and HOLD→ISSUE.
- Timeout: counter clears on entry to REQ/DRAIN and increments each REQ/DRAIN cycle with mem_ack=0. When it reaches TIMEOUT_CYCLES: fetch_error <= 1, mem_req <= 0, state IDLE. fetch_error clears only on reset. A late mem_ack in IDLE is ignored.
- Address arithmetic is the PC's job; this block never adds to addresses. Wrap 0xFFFF→0x0000 is seen only through pc_in.

Test Plan:
- Reset PC=0x0000, enable=1, mem_ack one cycle after each mem_req, instr_ready=1 → mem_addr sequence 0x0000, 0x0001, 0x0002; instr_pc matches; one pc_inc per fetch.
- Memory returns 0xBEEF at 0x0000, instr_ready=0 for 5 cycles → instr=0xBEEF, instr_valid stays 1 and stable, no new mem_req until ready.
- redirect_valid with redirect_addr=0x1234 while in REQ and ack delayed 3 cycles → DRAIN holds the request, returned data discarded, next mem_addr=0x1234, no pc_inc for the dropped word.
- redirect_valid and mem_ack in the same cycle → pc_load=1, pc_inc=0, instr_valid stays 0, next fetch at target.
- mem_ack never asserted, TIMEOUT_CYCLES=255 → fetch_error=1 after 255 REQ cycles, mem_req=0, IDLE held despite enable=1 until reset_n pulse.
- reset_n pulled low mid-REQ → mem_req, instr_valid drop immediately without clk; after release fetch restarts from pc_in.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer between the program counter and decode.
// Reads one instruction word per memory req/ack transaction into a single-entry
// buffer, owns PC advance (pc_inc) and branch redirect (pc_load), and flags a
// sticky error when memory fails to answer within TIMEOUT_CYCLES.
module instr_fetch_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_value,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fetch_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count holds completed no-ack cycles, so the last allowed value is one
  // below the limit: hitting it without an ack ends the transaction.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    REQ   = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    instr_valid_q, instr_valid_d;
  logic                    fetch_error_q, fetch_error_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pc_inc_c;
  logic                    timeout_c;

  // Next-state, buffer update and Mealy PC controls.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_error_d = fetch_error_q;
    cnt_d         = cnt_q;
    pc_inc_c      = 1'b0;
    timeout_c     = 1'b0;

    case (state_q)
      IDLE: begin
        // A redirect here only reloads the PC; fetching resumes next cycle.
        if (!redirect_valid && enable && !fetch_error_q) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // pc_in already reflects any increment/load from the previous edge.
        addr_d  = pc_in;
        cnt_d   = '0;
        state_d = redirect_valid ? ISSUE : REQ;
      end

      REQ: begin
        if (mem_ack) begin
          if (redirect_valid) begin
            // Word belongs to the abandoned path: drop it, refetch at target.
            state_d = ISSUE;
          end else begin
            instr_d       = mem_rdata;
            instr_pc_d    = addr_q;
            instr_valid_d = 1'b1;
            pc_inc_c      = 1'b1;
            state_d       = HOLD;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_c = 1'b1;
        end else if (redirect_valid) begin
          // Request must stay up until memory answers; wait it out in DRAIN.
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        if (mem_ack) begin
          state_d = ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          state_d = ISSUE;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = enable ? ISSUE : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_c) begin
      fetch_error_d = 1'b1;
      state_d       = IDLE;
    end

    // Any redirect invalidates whatever sits in the buffer.
    if (redirect_valid) begin
      instr_valid_d = 1'b0;
    end
  end

  // Request is registered: high exactly while in REQ or DRAIN.
  assign mem_req_d = (state_d == REQ) || (state_d == DRAIN);

  // State and datapath registers; async reset drops mem_req immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      addr_q        <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_error_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_error_q <= fetch_error_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pc_inc        = pc_inc_c & reset_n;
  assign pc_load       = redirect_valid & reset_n;
  assign pc_load_value = redirect_addr;
  assign mem_req       = mem_req_q;
  assign mem_addr      = addr_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_error   = fetch_error_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC model, a memory responder and
// a scoreboard of expected (address, word) pairs consumed at decode.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pc_q;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_error;

  instr_fetch_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pc_in(pc_q),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] req_log[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0000) ? 16'hBEEF : (a ^ 16'h5A3C);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Program counter model: reset value, increment and load as driven by DUT.
  logic [15:0] pc_rst_val = 16'h0000;
  int          inc_cnt = 0;
  int          load_cnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= pc_rst_val;
    end else begin
      if (pc_load)     pc_q <= pc_load_value;
      else if (pc_inc) pc_q <= pc_q + 16'h1;
      if (pc_inc)  inc_cnt  <= inc_cnt + 1;
      if (pc_load) load_cnt <= load_cnt + 1;
    end
  end

  // Memory responder: acks after mem_delay extra cycles (-1 = never).
  int   mem_delay = 1;
  int   wait_n = 0;
  logic late_tok = 1'b0;
  logic late_seen = 1'b0;
  always @(negedge clk) begin
    late_seen <= late_tok;
    if (!reset_n) begin
      mem_ack <= 1'b0;
      wait_n  <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      wait_n  <= 0;
    end else if (late_tok != late_seen) begin
      mem_ack   <= 1'b1;
      mem_rdata <= 16'hDEAD;
    end else if (mem_req) begin
      if (mem_delay >= 0 && wait_n >= mem_delay) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem_word(mem_addr);
      end else begin
        wait_n <= wait_n + 1;
      end
    end else begin
      wait_n <= 0;
    end
  end

  // Request monitor: logs each new request address, counts address changes mid-request.
  logic        req_prev = 1'b0;
  logic [15:0] addr_prev = 16'h0;
  int          addr_viol = 0;
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_log.push_back(mem_addr);
    if (mem_req && req_prev && mem_addr != addr_prev) addr_viol <= addr_viol + 1;
    req_prev  <= mem_req;
    addr_prev <= mem_addr;
  end

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(mem_req), 32'd1);
  endtask

  // Waits for a buffered instruction, compares it with the scoreboard head,
  // lets decode take it, and leaves the bench one negedge later.
  task automatic fetch_check(input string tag, input bit last);
    int   n = 0;
    exp_t e;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    if (instr_valid) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_instr"}, 32'(instr), 32'(e.data));
        chk({tag, "_instr_pc"}, 32'(instr_pc), 32'(e.addr));
      end
      if (last) enable = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          sz;
    int          inc0;
    int          load0;
    exp_t        e;
    logic [15:0] last_addr;

    // Reset state, with a redirect request that must be masked.
    redirect_valid = 1'b1;
    redirect_addr  = 16'h7777;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_error", 32'(fetch_error), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Sequential fetch 0,1,2 with one-cycle memory latency.
    mem_delay   = 1;
    instr_ready = 1'b1;
    enable      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.addr = 16'(i);
      e.data = mem_word(16'(i));
      sb.push_back(e);
    end
    @(negedge clk);
    chk("lat_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("lat_req_high", 32'(mem_req), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd0);
    fetch_check("seq0", 1'b0);
    fetch_check("seq1", 1'b0);
    fetch_check("seq2", 1'b1);
    repeat (3) @(negedge clk);
    chk("seq_idle_req", 32'(mem_req), 32'd0);
    chk("seq_req_count", 32'(req_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      chk("seq_req_addr", 32'(req_log[i]), 32'(i));
    end
    chk("seq_inc_count", 32'(inc_cnt), 32'd3);
    chk("seq_load_count", 32'(load_cnt), 32'd0);

    // Redirect from IDLE to 0x0000, then stalled decode with zero-wait memory.
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0000;
    #1;
    chk("idle_redir_load", 32'(pc_load), 32'd1);
    chk("idle_redir_value", 32'(pc_load_value), 32'd0);
    chk("idle_redir_inc", 32'(pc_inc), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_delay   = 0;
    instr_ready = 1'b0;
    enable      = 1'b1;
    e.addr = 16'h0000;
    e.data = 16'hBEEF;
    sb.push_back(e);
    sz = req_log.size();
    repeat (2) begin
      @(negedge clk);
      chk("zw_valid_early", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    chk("zw_valid_3rd_edge", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", 32'(instr), 32'hBEEF);
      chk("stall_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    fetch_check("stall", 1'b1);
    repeat (2) @(negedge clk);
    chk("stall_req_count", 32'(req_log.size()), 32'(sz + 1));

    // Redirect in REQ with ack three cycles late: DRAIN and discard.
    mem_delay = 3;
    enable    = 1'b1;
    wait_req("drain");
    chk("drain_first_addr", 32'(mem_addr), 32'h0001);
    e.addr = 16'h1234;
    e.data = mem_word(16'h1234);
    sb.push_back(e);
    redirect_valid = 1'b1;
    redirect_addr  = 16'h1234;
    #1;
    chk("drain_pc_load", 32'(pc_load), 32'd1);
    chk("drain_pc_inc", 32'(pc_inc), 32'd0);
    inc0  = inc_cnt;
    load0 = load_cnt;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drain_req_held", 32'(mem_req), 32'd1);
    chk("drain_addr_held", 32'(mem_addr), 32'h0001);
    chk("drain_valid_low", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("drain_req_held2", 32'(mem_req), 32'd1);
    chk("drain_addr_held2", 32'(mem_addr), 32'h0001);
    fetch_check("drain", 1'b1);
    repeat (2) @(negedge clk);
    chk("drain_inc_delta", 32'(inc_cnt - inc0), 32'd1);
    chk("drain_load_delta", 32'(load_cnt - load0), 32'd1);
    last_addr = req_log[req_log.size() - 1];
    chk("drain_next_addr", 32'(last_addr), 32'h1234);

    // Redirect coinciding with mem_ack.
    mem_delay = 1;
    enable    = 1'b1;
    wait_req("coinc");
    chk("coinc_addr", 32'(mem_addr), 32'h1235);
    @(negedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0040;
    #1;
    chk("coinc_pc_load", 32'(pc_load), 32'd1);
    chk("coinc_pc_inc", 32'(pc_inc), 32'd0);
    chk("coinc_load_value", 32'(pc_load_value), 32'h0040);
    inc0 = inc_cnt;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("coinc_valid_low", 32'(instr_valid), 32'd0);
    e.addr = 16'h0040;
    e.data = mem_word(16'h0040);
    sb.push_back(e);
    fetch_check("coinc", 1'b1);
    repeat (2) @(negedge clk);
    chk("coinc_inc_delta", 32'(inc_cnt - inc0), 32'd1);
    last_addr = req_log[req_log.size() - 1];
    chk("coinc_next_addr", 32'(last_addr), 32'h0040);

    // Memory never answers: timeout after 255 request cycles.
    mem_delay = -1;
    enable    = 1'b1;
    wait_req("tmo");
    n = 0;
    while (mem_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 32'(n), 32'd255);
    chk("tmo_error", 32'(fetch_error), 32'd1);
    chk("tmo_req_low", 32'(mem_req), 32'd0);
    late_tok = ~late_tok;
    repeat (3) @(negedge clk);
    chk("tmo_late_ack_ignored", 32'(instr_valid), 32'd0);
    sz = req_log.size();
    repeat (10) @(negedge clk);
    chk("tmo_idle_req", 32'(mem_req), 32'd0);
    chk("tmo_error_sticky", 32'(fetch_error), 32'd1);
    chk("tmo_no_new_req", 32'(req_log.size()), 32'(sz));
    pc_rst_val = 16'h0100;
    reset_n = 1'b0;
    #1;
    chk("tmo_error_cleared", 32'(fetch_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-REQ drops outputs without a clock edge, then fetch restarts.
    wait_req("rstreq");
    chk("rstreq_addr", 32'(mem_addr), 32'h0100);
    repeat (2) @(negedge clk);
    #2;
    pc_rst_val = 16'h0200;
    reset_n = 1'b0;
    #1;
    chk("rstreq_req_drop", 32'(mem_req), 32'd0);
    chk("rstreq_valid_drop", 32'(instr_valid), 32'd0);
    chk("rstreq_addr_clear", 32'(mem_addr), 32'd0);
    @(negedge clk);
    mem_delay = 1;
    e.addr = 16'h0200;
    e.data = mem_word(16'h0200);
    sb.push_back(e);
    reset_n = 1'b1;
    enable  = 1'b1;
    fetch_check("restart", 1'b1);
    repeat (2) @(negedge clk);
    last_addr = req_log[req_log.size() - 1];
    chk("restart_addr", 32'(last_addr), 32'h0200);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("addr_stable", 32'(addr_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
